// File: rtl/divmmc_pager.sv
// DivMMC-style paging controller: port E3 decode, M1 fetch traps, NMI latch and
// write protection for the 0x0000-0x3FFF window. DIVMMC_PAGER_RDPORT_EN adds a port E3 readback.
module divmmc_pager #(
  parameter int PAGEBITS = 4,
  parameter bit ROM3Q    = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ce,
  input  logic                enable,
  input  logic                rom3,
  input  logic                nmibtn,
  input  logic                mreq,
  input  logic                iorq,
  input  logic                wr,
  input  logic                m1,
  input  logic [15:0]         a,
  input  logic [7:0]          d,
  output logic                map,
  output logic                ram,
  output logic [PAGEBITS-1:0] page,
  output logic                wp,
  output logic                nmi
`ifdef DIVMMC_PAGER_RDPORT_EN
  ,
  output logic [7:0]          q,
  output logic                qe
`endif
);

  localparam logic [PAGEBITS-1:0] PAGE3 = PAGEBITS'(3);

  logic [7:0] porte3_q, porte3_d;
  logic       automap_q, automap_d;
  logic       pend_q, pend_d;
  logic       nmipend_q, nmipend_d;
  logic       nmibtn_q, nmibtn_d;

  logic fetch, rom_ok, cls_r, cls_x, cls_d, cls_o, port_hit, port_wr;
  logic unused_porte3;

  assign fetch    = !mreq && !m1 && enable;
  assign rom_ok   = ROM3Q ? rom3 : 1'b1;
  assign cls_r    = ((a == 16'h04C6) || (a == 16'h0562)) && rom_ok;
  assign cls_x    = (a[15:8] == 8'h3D) && rom_ok;
  assign cls_d    = (a == 16'h0000) || (a == 16'h0008) || (a == 16'h0038) ||
                    ((a == 16'h0066) && nmipend_q);
  assign cls_o    = (a[15:3] == 13'h03FF);
  assign port_hit = !iorq && (a[7:0] == 8'hE3);
  assign port_wr  = port_hit && !wr;

  // Bits above the page field are held for software but never steer paging.
  assign unused_porte3 = ^porte3_q[5:0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      porte3_q  <= 8'h00;
      automap_q <= 1'b0;
      pend_q    <= 1'b0;
      nmipend_q <= 1'b0;
      nmibtn_q  <= 1'b0;
    end else begin
      porte3_q  <= porte3_d;
      automap_q <= automap_d;
      pend_q    <= pend_d;
      nmipend_q <= nmipend_d;
      nmibtn_q  <= nmibtn_d;
    end
  end

  always_comb begin
    porte3_d  = porte3_q;
    automap_d = automap_q;
    pend_d    = pend_q;
    nmipend_d = nmipend_q;
    nmibtn_d  = nmibtn_q;
    if (ce) begin
      nmibtn_d = nmibtn;
      // MAPRAM can only be set by software; reset is the sole way to clear it.
      if (port_wr)
        porte3_d = {d[7], d[6] | porte3_q[6], d[5:0]};
      if (!enable) begin
        automap_d = 1'b0;
        pend_d    = 1'b0;
      end else if (fetch) begin
        if (cls_d || cls_r) begin
          pend_d = 1'b1;
        end else if (cls_o) begin
          pend_d = 1'b0;
        end else if (cls_x) begin
          automap_d = 1'b1;
          pend_d    = 1'b1;
        end
      end else if (m1) begin
        automap_d = pend_q;
      end
      if (nmibtn && !nmibtn_q)
        nmipend_d = 1'b1;
      else if (fetch && cls_o)
        nmipend_d = 1'b0;
    end
  end

  assign map  = porte3_q[7] | automap_q;
  assign ram  = porte3_q[6];
  assign page = (!a[13] && porte3_q[6]) ? PAGE3 : porte3_q[PAGEBITS-1:0];
  assign nmi  = !(nmipend_q && !map);

  // ROM half is always read-only; with MAPRAM, page 3 is read-only in either half.
  assign wp = map && !wr && !mreq && (a[15:14] == 2'b00) &&
              ((porte3_q[6] && (!a[13] || (porte3_q[PAGEBITS-1:0] == PAGE3))) ||
               (!porte3_q[6] && !a[13]));

`ifdef DIVMMC_PAGER_RDPORT_EN
  always_comb begin
    q  = 8'hFF;
    qe = 1'b0;
    if (port_hit && wr && m1) begin
      q  = porte3_q;
      qe = 1'b1;
    end
  end
`endif

endmodule
